// File: rtl/alu_seq_pkg.sv
// alu_seq shared types: opcodes, FSM states, legal-opcode limit.
// ALU_SEQ_ROTATE_EN makes ROL/ROR legal.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_XOR = 4'd2,
    OP_SHL = 4'd3,
    OP_SHR = 4'd4,
    OP_MOD = 4'd5,
    OP_ROL = 4'd6,
    OP_ROR = 4'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef ALU_SEQ_ROTATE_EN
  localparam op_e OP_LAST_LEGAL = OP_ROR;
`else
  localparam op_e OP_LAST_LEGAL = OP_MOD;
`endif

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an initiator and alu_seq_core.
// master = initiator side, slave = execution unit side.
interface alu_seq_if #(
  parameter int N = 4
);
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [N-1:0] data_shifts;
  logic [N-1:0] shift_number;
  logic [3:0]   operation;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] y;
  logic         err;

  modport master (
    output req_valid, a, b,
    output data_shifts, shift_number,
    output operation, rsp_ready,
    input  req_ready, rsp_valid,
    input  y, err
  );

  modport slave (
    input  req_valid, a, b,
    input  data_shifts, shift_number,
    input  operation, rsp_ready,
    output req_ready, rsp_valid,
    output y, err
  );
endinterface

// File: rtl/alu_mod_iter.sv
// Iterative restoring remainder unit: one quotient bit per cycle.
// done is high during the last iteration; remainder is valid then.
module alu_mod_iter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] remainder
);
  localparam int CW = $clog2(N + 1);

  logic [N:0]    rem;
  logic [N:0]    rem_nxt;
  logic [N:0]    trial;
  logic [N-1:0]  dvd;
  logic [N-1:0]  dsr;
  logic [CW-1:0] cnt;

  always_comb begin
    trial = (rem << 1) | {{N{1'b0}}, dvd[N-1]};
    rem_nxt = trial;
    if (trial >= {1'b0, dsr})
      rem_nxt = trial - {1'b0, dsr};
  end

  assign done      = busy && (cnt == '0);
  assign remainder = rem_nxt[N-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      dvd  <= '0;
      dsr  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      dvd  <= dividend;
      dsr  <= divisor;
      cnt  <= CW'(N - 1);
      busy <= 1'b1;
    end else if (busy) begin
      rem <= rem_nxt;
      dvd <= {dvd[N-2:0], 1'b0};
      cnt <= cnt - 1'b1;
      if (cnt == '0)
        busy <= 1'b0;
    end
  end
endmodule

// File: rtl/alu_seq_core.sv
// Handshaked sequential ALU: 1-cycle logic/shift ops, N-cycle MOD.
// ALU_SEQ_ROTATE_EN adds ROL/ROR (opcodes 6/7).
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int N = 4
) (
  input logic   clk,
  input logic   rst,
  alu_seq_if.slave bus
);
  localparam logic [N-1:0] NV = N'(N);

  state_e       state;
  state_e       state_nxt;
  op_e          op;
  logic         illegal;
  logic         accept;
  logic         mod_go;
  logic [N-1:0] res;
  logic         res_err;
  logic [N-1:0] y_q;
  logic         err_q;
  logic         div_busy;
  logic         div_done;
  logic [N-1:0] div_rem;

`ifdef ALU_SEQ_ROTATE_EN
  logic [N-1:0]   rot_amt;
  logic [2*N-1:0] rol_w;
  logic [2*N-1:0] ror_w;

  always_comb begin
    rot_amt = bus.shift_number % NV;
    rol_w = {bus.data_shifts, bus.data_shifts} << rot_amt;
    ror_w = {bus.data_shifts, bus.data_shifts} >> rot_amt;
  end
`endif

  always_comb begin
    op      = op_e'(bus.operation);
    illegal = bus.operation > OP_LAST_LEGAL;
    res     = '0;
    res_err = 1'b0;
    if (illegal) begin
      res_err = 1'b1;
    end else begin
      case (op)
        OP_AND: res = bus.a & bus.b;
        OP_OR:  res = bus.a | bus.b;
        OP_XOR: res = bus.a ^ bus.b;
        OP_SHL: res = (bus.shift_number >= NV) ? '0
                : bus.data_shifts << bus.shift_number;
        OP_SHR: res = (bus.shift_number >= NV) ? '0
                : bus.data_shifts >> bus.shift_number;
        // nonzero divisor: y comes from the divider instead
        OP_MOD: begin
          res     = bus.a;
          res_err = (bus.b == '0);
        end
`ifdef ALU_SEQ_ROTATE_EN
        OP_ROL: res = rol_w[2*N-1:N];
        OP_ROR: res = ror_w[N-1:0];
`endif
        default: begin
          res     = '0;
          res_err = 1'b1;
        end
      endcase
    end
  end

  assign accept = (state == IDLE) && bus.req_valid;
  assign mod_go = accept && !illegal
                  && (op == OP_MOD) && (bus.b != '0);

  alu_mod_iter #(.N(N)) u_mod (
    .clk      (clk),
    .rst      (rst),
    .start    (mod_go),
    .dividend (bus.a),
    .divisor  (bus.b),
    .busy     (div_busy),
    .done     (div_done),
    .remainder(div_rem)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      (state == IDLE):
        if (accept) state_nxt = mod_go ? EXEC : DONE;
      (state == EXEC):
        if (div_done || !div_busy) state_nxt = DONE;
      (state == DONE):
        if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == DONE);
    bus.y         = y_q;
    bus.err       = err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q   <= '0;
      err_q <= 1'b0;
    end else if (accept && !mod_go) begin
      y_q   <= res;
      err_q <= res_err;
    end else if ((state == EXEC) && div_done) begin
      y_q   <= div_rem;
      err_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_seq_core.sv
// Self-checking bench for alu_seq_core (N=4): directed table,
// hold/reset sequences, and random ops against an arithmetic model.
module tb_alu_seq_core;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_seq_if #(.N(N)) bus();

  alu_seq_core #(.N(N)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [3:0] op, a, b, ds, sn, y;
    logic       e;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  function automatic void add(input string n,
      input logic [3:0] op, a, b, ds, sn, y,
      input logic e, input int lat);
    vec_t v;
    v.name = n; v.op = op; v.a = a; v.b = b;
    v.ds = ds; v.sn = sn; v.y = y; v.e = e;
    v.lat = lat;
    vecs.push_back(v);
  endfunction

  function automatic void model(
      input logic [3:0] op, a, b, ds, sn,
      output logic [3:0] y, output logic e,
      output int lat);
    int ia, ib, id, is, r;
    ia = int'(a); ib = int'(b);
    id = int'(ds); is = int'(sn);
    y = 4'd0; e = 1'b0; lat = 1;
    case (op)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = a ^ b;
      4'd3: if (is < N) y = 4'((id * (1 << is)) % 16);
      4'd4: if (is < N) y = 4'(id / (1 << is));
      4'd5: begin
        if (ib == 0) begin
          y = a; e = 1'b1;
        end else begin
          y = 4'(ia % ib); lat = N + 1;
        end
      end
`ifdef ALU_SEQ_ROTATE_EN
      4'd6: begin
        r = is % N;
        y = 4'(((id << r) | (id >> (N - r))) & 15);
      end
      4'd7: begin
        r = is % N;
        y = 4'(((id >> r) | (id << (N - r))) & 15);
      end
`endif
      default: e = 1'b1;
    endcase
  endfunction

  task automatic scramble();
    bus.operation    = 4'($urandom);
    bus.a            = 4'($urandom);
    bus.b            = 4'($urandom);
    bus.data_shifts  = 4'($urandom);
    bus.shift_number = 4'($urandom);
  endtask

  task automatic do_op(input string name,
      input logic [3:0] op, a, b, ds, sn,
      input logic [3:0] ey, input logic ee,
      input int elat, input int hold);
    int lat;
    bit rdy_seen;
    chk({name, "_req_ready"}, bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.operation = op; bus.a = a; bus.b = b;
    bus.data_shifts = ds; bus.shift_number = sn;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    scramble();
    lat = 1;
    rdy_seen = 1'b0;
    while (!bus.rsp_valid && lat < 20) begin
      if (bus.req_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_latency"}, lat, elat);
    chk({name, "_busy_ready"}, rdy_seen, 0);
    repeat (hold) begin
      @(posedge clk); #1;
    end
    chk({name, "_valid"}, bus.rsp_valid, 1);
    chk({name, "_y"}, bus.y, ey);
    chk({name, "_err"}, bus.err, ee);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({name, "_idle"},
        {bus.rsp_valid, bus.req_ready}, 2'b01);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] op, a, b, ds, sn, ey;
    logic       ee;
    int         el;
    bit         seen;

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.operation = 4'd0; bus.a = 4'd0; bus.b = 4'd0;
    bus.data_shifts = 4'd0; bus.shift_number = 4'd0;

    add("and",   4'd0, 4'hA, 4'hC, 4'h0, 4'h0, 4'h8, 0, 1);
    add("or",    4'd1, 4'hA, 4'hC, 4'h0, 4'h0, 4'hE, 0, 1);
    add("xor",   4'd2, 4'hA, 4'hC, 4'h0, 4'h0, 4'h6, 0, 1);
    add("mod15_6", 4'd5, 4'hF, 4'h6, 4'h0, 4'h0, 4'h3, 0, 5);
    add("mod10_2", 4'd5, 4'hA, 4'h2, 4'h0, 4'h0, 4'h0, 0, 5);
    add("mod_by0", 4'd5, 4'hA, 4'h0, 4'h0, 4'h0, 4'hA, 1, 1);
    add("op15",  4'hF, 4'h5, 4'h3, 4'h0, 4'h0, 4'h0, 1, 1);
    add("shl2",  4'd3, 4'h0, 4'h0, 4'hE, 4'h2, 4'h8, 0, 1);
    add("shr2",  4'd4, 4'h0, 4'h0, 4'h4, 4'h2, 4'h1, 0, 1);
    add("shl4",  4'd3, 4'h0, 4'h0, 4'hE, 4'h4, 4'h0, 0, 1);
    add("shr7",  4'd4, 4'h0, 4'h0, 4'hF, 4'h7, 4'h0, 0, 1);
`ifdef ALU_SEQ_ROTATE_EN
    add("rol1",  4'd6, 4'h0, 4'h0, 4'h9, 4'h1, 4'h3, 0, 1);
    add("ror5",  4'd7, 4'h0, 4'h0, 4'h9, 4'h5, 4'hC, 0, 1);
`else
    add("op6",   4'd6, 4'h0, 4'h0, 4'h9, 4'h1, 4'h0, 1, 1);
    add("op7",   4'd7, 4'h0, 4'h0, 4'h9, 4'h5, 4'h0, 1, 1);
`endif

    // reset with a request pending: must be ignored
    bus.req_valid = 1'b1;
    bus.a = 4'hF; bus.b = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.rsp_valid, 0);
    chk("rst_y", bus.y, 0);
    chk("rst_err", bus.err, 0);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    chk("rst_ready", bus.req_ready, 1);

    foreach (vecs[i])
      do_op(vecs[i].name, vecs[i].op, vecs[i].a,
            vecs[i].b, vecs[i].ds, vecs[i].sn,
            vecs[i].y, vecs[i].e, vecs[i].lat, 0);

    // stall the response while a new request waits
    bus.req_valid = 1'b1;
    bus.operation = 4'd0; bus.a = 4'hF; bus.b = 4'h3;
    @(posedge clk); #1;
    bus.operation = 4'd1; bus.a = 4'h0; bus.b = 4'hC;
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", bus.rsp_valid, 1);
      chk("hold_y", bus.y, 4'h3);
      chk("hold_err", bus.err, 0);
      chk("hold_ready", bus.req_ready, 0);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("hold_idle", {bus.rsp_valid, bus.req_ready}, 2'b01);
    @(posedge clk); #1;
    chk("hold_no_accept", bus.rsp_valid, 0);

    // reset in the 3rd EXEC cycle of 15 % 6
    bus.req_valid = 1'b1;
    bus.operation = 4'd5; bus.a = 4'hF; bus.b = 4'h6;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", bus.rsp_valid, 0);
    chk("abort_y", bus.y, 0);
    chk("abort_ready", bus.req_ready, 1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("abort_no_rsp", seen, 0);
    do_op("post_abort_and", 4'd0, 4'hA, 4'hC, 4'h0, 4'h0,
          4'h8, 1'b0, 1, 0);

    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0)
        op = 4'($urandom_range(8, 15));
      else
        op = 4'($urandom_range(0, 7));
      a  = 4'($urandom);
      b  = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
      ds = 4'($urandom);
      sn = 4'($urandom);
      model(op, a, b, ds, sn, ey, ee, el);
      do_op($sformatf("rnd%0d_op%0d", i, op), op, a, b,
            ds, sn, ey, ee, el, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
